// File: rtl/eaf_request_scheduler_pkg.sv
// eaf_sched_pkg: shared types and default parameters for the EAF request scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, request-kind encoding, default parameter values.
package eaf_sched_pkg;

   localparam int unsigned DEF_ADDR_LENGTH        = 32;
   localparam int unsigned DEF_MAX_NUM_OF_ENTRIES = 16;
   localparam int unsigned DEF_INS_FIFO_DEPTH     = 4;
   localparam int unsigned DEF_STARVE_LIMIT       = 4;
   localparam int unsigned DEF_STAT_WIDTH         = 32;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE_TEST = 3'd1,
      ST_WAIT_TEST  = 3'd2,
      ST_ISSUE_INS  = 3'd3,
      ST_WAIT_INS   = 3'd4,
      ST_CLEAR      = 3'd5
   } eaf_sched_state_e;

   typedef enum logic {
      REQ_TEST   = 1'b0,
      REQ_INSERT = 1'b1
   } eaf_req_kind_e;

endpackage

// File: rtl/eaf_insert_fifo.sv
// eaf_insert_fifo: synchronous FIFO buffering evicted addresses until the EAF port is free.
// Latency: push visible at head_o the cycle after the push edge.
// Backpressure: pushes while full_o are dropped (requester holds); pops while empty_o are ignored.
// Ports: clk, rst (async active-low), push_i/push_dat_i, pop_i, head_o, full_o, empty_o.
module eaf_insert_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_dat_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   // One extra wrap bit on each pointer distinguishes full from empty.
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok, pop_ok;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
   end

endmodule

// File: rtl/eaf_request_scheduler.sv
// eaf_request_scheduler: arbitrates miss-address tests and buffered eviction inserts onto the single EAF port.
// Latency: test ack->done >= 3 cycles; insert pop->strobe 1 cycle; filter clear 1 cycle after the filling insert completes.
// Backpressure: test_req_i held until test_ack_o; ins_req_i held while ins_ready_o is low (insert FIFO full).
// Ports: test_* (request/ack/result), ins_* (insert push), eaf_* (filter command/response), busy_o, ins_count_o.
// Optional: EAF_SCHED_STATS_EN adds saturating completion counters stat_tests_o/stat_hits_o/stat_inserts_o/stat_clears_o.
module eaf_request_scheduler
   import eaf_sched_pkg::*;
#(
   parameter int unsigned ADDR_LENGTH        = DEF_ADDR_LENGTH,
   parameter int unsigned MAX_NUM_OF_ENTRIES = DEF_MAX_NUM_OF_ENTRIES,
   parameter int unsigned INS_FIFO_DEPTH     = DEF_INS_FIFO_DEPTH,
   parameter int unsigned STARVE_LIMIT       = DEF_STARVE_LIMIT,
   parameter int unsigned STAT_WIDTH         = DEF_STAT_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  test_req_i,
   input  logic [ADDR_LENGTH-1:0]                test_addr_i,
   output logic                                  test_ack_o,
   output logic                                  test_done_o,
   output logic                                  test_priority_o,
   output logic                                  test_exists_o,
   input  logic                                  ins_req_i,
   input  logic [ADDR_LENGTH-1:0]                ins_addr_i,
   output logic                                  ins_ready_o,
   output logic [ADDR_LENGTH-1:0]                eaf_addr_o,
   output logic                                  eaf_insert_o,
   output logic                                  eaf_test_o,
   output logic                                  eaf_clear_o,
   input  logic                                  eaf_resp_i,
   input  logic                                  eaf_priority_i,
   input  logic                                  eaf_exists_i,
   output logic                                  busy_o,
`ifdef EAF_SCHED_STATS_EN
   output logic [STAT_WIDTH-1:0]                 stat_tests_o,
   output logic [STAT_WIDTH-1:0]                 stat_hits_o,
   output logic [STAT_WIDTH-1:0]                 stat_inserts_o,
   output logic [STAT_WIDTH-1:0]                 stat_clears_o,
`endif
   output logic [$clog2(MAX_NUM_OF_ENTRIES+1)-1:0] ins_count_o
);

   localparam int unsigned CNT_W = $clog2(MAX_NUM_OF_ENTRIES + 1);
   localparam int unsigned SC_W  = $clog2(STARVE_LIMIT + 1);

   eaf_sched_state_e       state_q, state_d;
   logic [ADDR_LENGTH-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]       ins_count_q, ins_count_d;
   logic [SC_W-1:0]        starve_q, starve_d;
   logic                   done_q, done_d;
   logic                   prio_q, prio_d;
   logic                   exists_q, exists_d;

   logic                   fifo_empty, fifo_full;
   logic [ADDR_LENGTH-1:0] fifo_head;
   logic                   idle_free, test_win, grant_vld, pop;
   eaf_req_kind_e          grant_kind;
   logic                   test_cpl, ins_cpl;

   eaf_insert_fifo #(
      .WIDTH (ADDR_LENGTH),
      .DEPTH (INS_FIFO_DEPTH)
   ) u_ins_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (ins_req_i),
      .push_dat_i (ins_addr_i),
      .pop_i      (pop),
      .head_o     (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   // The cycle test_done_o pulses is spent in IDLE but must not grant.
   assign idle_free = (state_q == ST_IDLE) && !done_q;
   assign test_win  = test_req_i && (fifo_empty || (starve_q < SC_W'(STARVE_LIMIT)));
   assign test_cpl  = (state_q == ST_WAIT_TEST) && eaf_resp_i;
   assign ins_cpl   = (state_q == ST_WAIT_INS) && eaf_resp_i;

   always_comb begin
      grant_vld  = 1'b0;
      grant_kind = REQ_TEST;
      if (idle_free) begin
         if (test_win) begin
            grant_vld = 1'b1;
         end else if (!fifo_empty) begin
            grant_vld  = 1'b1;
            grant_kind = REQ_INSERT;
         end
      end
   end

   assign pop        = grant_vld && (grant_kind == REQ_INSERT);
   assign test_ack_o = grant_vld && (grant_kind == REQ_TEST);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      ins_count_d = ins_count_q;
      done_d      = 1'b0;
      prio_d      = prio_q;
      exists_d    = exists_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_vld) begin
               if (grant_kind == REQ_TEST) begin
                  state_d = ST_ISSUE_TEST;
                  addr_d  = test_addr_i;
               end else begin
                  state_d = ST_ISSUE_INS;
                  addr_d  = fifo_head;
               end
            end
         end
         ST_ISSUE_TEST: state_d = ST_WAIT_TEST;
         ST_WAIT_TEST: begin
            if (test_cpl) begin
               prio_d   = eaf_priority_i;
               exists_d = eaf_exists_i;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_ISSUE_INS: state_d = ST_WAIT_INS;
         ST_WAIT_INS: begin
            if (ins_cpl) begin
               ins_count_d = ins_count_q + 1'b1;
               state_d     = (ins_count_d == CNT_W'(MAX_NUM_OF_ENTRIES)) ? ST_CLEAR : ST_IDLE;
            end
         end
         ST_CLEAR: begin
            ins_count_d = '0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Starvation only accrues while an insert is actually waiting; a test grant
   // is only possible below the limit, so the counter cannot overflow.
   always_comb begin
      starve_d = starve_q;
      if (fifo_empty || pop) begin
         starve_d = '0;
      end else if (test_ack_o) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         ins_count_q <= '0;
         starve_q    <= '0;
         done_q      <= 1'b0;
         prio_q      <= 1'b0;
         exists_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         ins_count_q <= ins_count_d;
         starve_q    <= starve_d;
         done_q      <= done_d;
         prio_q      <= prio_d;
         exists_q    <= exists_d;
      end
   end

   assign test_done_o     = done_q;
   assign test_priority_o = prio_q;
   assign test_exists_o   = exists_q;
   assign ins_ready_o     = !fifo_full;
   assign eaf_test_o      = (state_q == ST_ISSUE_TEST);
   assign eaf_insert_o    = (state_q == ST_ISSUE_INS);
   assign eaf_clear_o     = (state_q == ST_CLEAR);
   assign eaf_addr_o      = (state_q == ST_ISSUE_TEST || state_q == ST_WAIT_TEST ||
                             state_q == ST_ISSUE_INS  || state_q == ST_WAIT_INS) ? addr_q : '0;
   assign busy_o          = (state_q != ST_IDLE) || !fifo_empty;
   assign ins_count_o     = ins_count_q;

`ifdef EAF_SCHED_STATS_EN
   logic [STAT_WIDTH-1:0] stat_tests_q, stat_hits_q, stat_inserts_q, stat_clears_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_tests_q   <= '0;
         stat_hits_q    <= '0;
         stat_inserts_q <= '0;
         stat_clears_q  <= '0;
      end else begin
         if (test_cpl && (stat_tests_q != '1))
            stat_tests_q <= stat_tests_q + 1'b1;
         if (test_cpl && eaf_exists_i && (stat_hits_q != '1))
            stat_hits_q <= stat_hits_q + 1'b1;
         if (ins_cpl && (stat_inserts_q != '1))
            stat_inserts_q <= stat_inserts_q + 1'b1;
         if ((state_q == ST_CLEAR) && (stat_clears_q != '1))
            stat_clears_q <= stat_clears_q + 1'b1;
      end
   end

   assign stat_tests_o   = stat_tests_q;
   assign stat_hits_o    = stat_hits_q;
   assign stat_inserts_o = stat_inserts_q;
   assign stat_clears_o  = stat_clears_q;
`endif

endmodule

// File: tb/tb_eaf_request_scheduler.sv
// tb_eaf_request_scheduler: self-checking bench for eaf_request_scheduler with default parameters.
// Latency: n/a.
// Backpressure: an EAF responder model answers each strobe after a programmable delay, or stalls.
module tb_eaf_request_scheduler;

   localparam int MAX = 16;

   logic        clk, rst;
   logic        test_req_i;
   logic [31:0] test_addr_i;
   logic        test_ack_o, test_done_o, test_priority_o, test_exists_o;
   logic        ins_req_i;
   logic [31:0] ins_addr_i;
   logic        ins_ready_o;
   logic [31:0] eaf_addr_o;
   logic        eaf_insert_o, eaf_test_o, eaf_clear_o;
   logic        eaf_resp_i, eaf_priority_i, eaf_exists_i;
   logic        busy_o;
   logic [4:0]  ins_count_o;
`ifdef EAF_SCHED_STATS_EN
   logic [31:0] stat_tests_o, stat_hits_o, stat_inserts_o, stat_clears_o;
`endif

   eaf_request_scheduler dut (
      .clk             (clk),
      .rst             (rst),
      .test_req_i      (test_req_i),
      .test_addr_i     (test_addr_i),
      .test_ack_o      (test_ack_o),
      .test_done_o     (test_done_o),
      .test_priority_o (test_priority_o),
      .test_exists_o   (test_exists_o),
      .ins_req_i       (ins_req_i),
      .ins_addr_i      (ins_addr_i),
      .ins_ready_o     (ins_ready_o),
      .eaf_addr_o      (eaf_addr_o),
      .eaf_insert_o    (eaf_insert_o),
      .eaf_test_o      (eaf_test_o),
      .eaf_clear_o     (eaf_clear_o),
      .eaf_resp_i      (eaf_resp_i),
      .eaf_priority_i  (eaf_priority_i),
      .eaf_exists_i    (eaf_exists_i),
      .busy_o          (busy_o),
`ifdef EAF_SCHED_STATS_EN
      .stat_tests_o    (stat_tests_o),
      .stat_hits_o     (stat_hits_o),
      .stat_inserts_o  (stat_inserts_o),
      .stat_clears_o   (stat_clears_o),
`endif
      .ins_count_o     (ins_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: got no matching event, required one", name);
   endtask

   // Scoreboard queues, filled by the stimulus side, drained by the monitor.
   logic [31:0] exp_taddr[$];
   logic [31:0] exp_iaddr[$];
   logic [1:0]  exp_res[$];
   int          exp_lat[$];
   int          ack_q[$];

   // EAF responder model.
   int   rsp_k = 1;
   logic rsp_prio = 1'b0, rsp_exists = 1'b0, stall = 1'b0;

   initial begin
      eaf_resp_i = 1'b0; eaf_priority_i = 1'b0; eaf_exists_i = 1'b0;
      forever begin
         @(negedge clk);
         if (rst && (eaf_test_o || eaf_insert_o)) begin
            for (int i = 0; i < 3000 && stall; i++) @(posedge clk);
            for (int i = 0; i < rsp_k; i++) begin @(posedge clk); #1; end
            eaf_resp_i = 1'b1; eaf_priority_i = rsp_prio; eaf_exists_i = rsp_exists;
            @(posedge clk); #1;
            eaf_resp_i = 1'b0; eaf_priority_i = 1'b0; eaf_exists_i = 1'b0;
         end
      end
   end

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   int cyc = 0, last_ack = 0, m_ins = 0, n_clear = 0, n_done = 0;
   bit ins_pending = 0, chk_cnt = 0, clr_next = 0;

   always @(negedge clk) begin
      if (!rst) begin
         exp_taddr.delete(); exp_iaddr.delete(); exp_res.delete(); exp_lat.delete(); ack_q.delete();
         m_ins = 0; ins_pending = 0; chk_cnt = 0; clr_next = 0;
      end else begin
         cyc++;
         if (chk_cnt) begin
            chk_cnt = 0;
            m_ins++;
            check("ins_count", ins_count_o, m_ins);
            check("clear_strobe", eaf_clear_o, (m_ins == MAX));
            if (m_ins == MAX) begin m_ins = 0; clr_next = 1; n_clear++; end
         end else if (clr_next) begin
            clr_next = 0;
            check("count_after_clear", ins_count_o, 0);
            check("clear_one_cycle", eaf_clear_o, 0);
         end else if (eaf_clear_o) begin
            fail("unexpected_clear");
         end
         if (eaf_resp_i && ins_pending) begin ins_pending = 0; chk_cnt = 1; end
         if (test_ack_o) begin last_ack = cyc; ack_q.push_back(cyc); end
         if (eaf_test_o) begin
            check("ack_to_test_strobe", cyc - last_ack, 1);
            if (exp_taddr.size() == 0) fail("unexpected_test_strobe");
            else check("test_addr", eaf_addr_o, exp_taddr.pop_front());
         end
         if (eaf_insert_o) begin
            ins_pending = 1;
            if (exp_iaddr.size() == 0) fail("unexpected_insert_strobe");
            else check("insert_addr", eaf_addr_o, exp_iaddr.pop_front());
         end
         if (test_done_o) begin
            n_done++;
            if (exp_res.size() == 0 || ack_q.size() == 0 || exp_lat.size() == 0) begin
               fail("unexpected_test_done");
            end else begin
               check("test_result", {test_priority_o, test_exists_o}, exp_res.pop_front());
               check("ack_to_done_cycles", cyc - ack_q.pop_front(), exp_lat.pop_front());
            end
         end
      end
   end

   // Stimulus tasks: all entered and left at posedge+1.
   task automatic req_test(input logic [31:0] a, input logic p, input logic e, input int k, input int lat);
      bit got = 0;
      rsp_k = k; rsp_prio = p; rsp_exists = e;
      exp_taddr.push_back(a); exp_res.push_back({p, e}); exp_lat.push_back(lat);
      test_req_i = 1'b1; test_addr_i = a;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (test_ack_o) got = 1;
         @(posedge clk); #1;
      end
      test_req_i = 1'b0;
      if (!got) fail("test_ack_timeout");
   endtask

   task automatic push_ins(input logic [31:0] a);
      bit got = 0;
      ins_req_i = 1'b1; ins_addr_i = a;
      for (int i = 0; i < 300 && !got; i++) begin
         if (ins_ready_o) begin got = 1; exp_iaddr.push_back(a); end
         @(posedge clk); #1;
      end
      ins_req_i = 1'b0;
      if (!got) fail("insert_push_timeout");
   endtask

   task automatic wait_idle(input string name);
      bit ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(posedge clk); #1;
         if (!busy_o && !test_done_o && !eaf_resp_i && exp_res.size() == 0 &&
             exp_iaddr.size() == 0 && exp_taddr.size() == 0) ok = 1;
      end
      if (!ok) fail(name);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic        prio;
      logic        exists;
      int          k;
      int          lat;
   } vec_t;

   vec_t vt[6];

   initial begin
      int acks_after_push, acks_after_ins, n_ack, done_before;
      bit pushed, ins_seen, acc;

      vt[0] = '{32'hDEAD_BEE0, 1'b1, 1'b1, 2, 4};
      vt[1] = '{32'h0000_0004, 1'b0, 1'b0, 1, 3};
      vt[2] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 1, 3};
      vt[3] = '{32'h1234_5678, 1'b0, 1'b1, 3, 5};
      vt[4] = '{32'h8000_0001, 1'b1, 1'b1, 5, 7};
      vt[5] = '{32'h0F0F_F0F0, 1'b0, 1'b0, 1, 3};

      rst = 1'b0; test_req_i = 1'b0; test_addr_i = '0; ins_req_i = 1'b0; ins_addr_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ins_ready", ins_ready_o, 1);
      check("rst_busy", busy_o, 0);
      check("rst_outputs", {test_done_o, eaf_test_o, eaf_insert_o, eaf_clear_o, test_ack_o}, 0);
      check("rst_ins_count", ins_count_o, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Single tests from the table: results and ack->done latency.
      for (int i = 0; i < 6; i++) begin
         req_test(vt[i].addr, vt[i].prio, vt[i].exists, vt[i].k, vt[i].lat);
         wait_idle("test_vector_idle");
      end

      // Three inserts, no tests: FIFO order and running count.
      rsp_k = 1; rsp_prio = 1'b0; rsp_exists = 1'b0;
      push_ins(32'hAAAA_0001);
      push_ins(32'hAAAA_0002);
      push_ins(32'hAAAA_0003);
      wait_idle("insert_idle");
      check("count_after_3", ins_count_o, 3);

      // Starvation bound: one waiting insert, tests requested continuously.
      rsp_k = 1; rsp_prio = 1'b1; rsp_exists = 1'b0;
      test_req_i = 1'b1; test_addr_i = 32'hA5A5_0000;
      n_ack = 0; acks_after_push = 0; acks_after_ins = 0; pushed = 0; ins_seen = 0;
      for (int c = 0; c < 400 && acks_after_ins < 1; c++) begin
         @(negedge clk);
         if (eaf_insert_o) ins_seen = 1;
         if (test_ack_o) begin
            n_ack++;
            exp_taddr.push_back(32'hA5A5_0000); exp_res.push_back(2'b10); exp_lat.push_back(3);
            if (pushed) begin
               if (ins_seen) acks_after_ins++;
               else acks_after_push++;
            end
         end
         @(posedge clk); #1;
         if (n_ack == 1 && !pushed) begin
            ins_req_i = 1'b1; ins_addr_i = 32'hBBBB_0001; exp_iaddr.push_back(32'hBBBB_0001); pushed = 1;
         end else begin
            ins_req_i = 1'b0;
         end
      end
      test_req_i = 1'b0; ins_req_i = 1'b0;
      check("tests_before_insert", acks_after_push, 4);
      check("tests_resume", acks_after_ins, 1);
      wait_idle("starve_idle");

      // FIFO full with EAF stalled: ready drops, held push lands the cycle after a pop.
      rsp_k = 1; rsp_prio = 1'b0; rsp_exists = 1'b0; stall = 1'b1;
      for (int i = 0; i < 5; i++) push_ins(32'hC000_0000 + i);
      check("ready_when_full", ins_ready_o, 0);
      ins_req_i = 1'b1; ins_addr_i = 32'hC000_0005; acc = 0;
      for (int c = 0; c < 400 && !acc; c++) begin
         @(negedge clk);
         if (eaf_insert_o) begin
            check("ready_after_pop", ins_ready_o, 1);
            exp_iaddr.push_back(32'hC000_0005);
            acc = 1;
         end else if (c < 3) begin
            check("ready_while_full", ins_ready_o, 0);
         end
         @(posedge clk); #1;
         if (c == 3) stall = 1'b0;
      end
      ins_req_i = 1'b0;
      if (!acc) fail("held_push_timeout");
      wait_idle("fifo_full_idle");
      check("count_before_clear", ins_count_o, 10);

      // Six more inserts reach 16 and trigger exactly one clear.
      for (int i = 0; i < 6; i++) push_ins(32'hD000_0000 + i);
      wait_idle("clear_idle");
      check("clears_seen", n_clear, 1);
      check("count_zero_after_clear", ins_count_o, 0);

      // Reset while a test waits on the EAF and an insert is queued.
      stall = 1'b1;
      req_test(32'hE000_0000, 1'b1, 1'b1, 1, 3);
      push_ins(32'hE000_0001);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("mid_rst_outputs", {test_done_o, eaf_test_o, eaf_insert_o, eaf_clear_o, test_ack_o}, 0);
      check("mid_rst_addr", eaf_addr_o, 0);
      check("mid_rst_ready", ins_ready_o, 1);
      check("mid_rst_busy", busy_o, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      done_before = n_done;
      stall = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("no_done_after_rst", n_done - done_before, 0);
      check("idle_after_rst", busy_o, 0);
      check("count_after_rst", ins_count_o, 0);
      check("scoreboard_drained", exp_res.size() + exp_iaddr.size() + exp_taddr.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
